// File: rtl/axi_lite_gpio_param.sv
// AXI4-Lite GPIO slave: byte-strobed output register, synchronised input port,
// per-button saturating press counters with optional clear-on-read and a level interrupt.
module axi_lite_gpio_param #(
    parameter int ADDR_W      = 6,
    parameter int OUT_W       = 16,
    parameter int IN_W        = 16,
    parameter int BTN_N       = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic [IN_W-1:0]   gpio_in,
    input  logic [BTN_N-1:0]  btn,
    output logic [OUT_W-1:0]  gpio_out,
    output logic              irq
);

    // Handshakes: a beat transfers on the rising edge where valid and ready are both high;
    // valid never waits on ready, and every ready/valid here is a registered flop.

    localparam int         IDX_W       = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              clk;
    logic              rst_n;
    assign clk   = s_axi_aclk;
    assign rst_n = s_axi_aresetn;

    logic [2:0]       cfg;
    logic [OUT_W-1:0] out_q;
    logic [IN_W-1:0]  in_sync  [SYNC_STAGES];
    logic [BTN_N-1:0] btn_sync [SYNC_STAGES];
    logic [BTN_N-1:0] btn_prev;
    logic [CNT_W-1:0] cnt      [BTN_N];

    logic             aw_hold, w_hold;
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    logic aw_fire, w_fire, b_fire, ar_fire, r_fire, wr_commit;
    assign aw_fire   = s_axi_awvalid & s_axi_awready;
    assign w_fire    = s_axi_wvalid & s_axi_wready;
    assign b_fire    = s_axi_bvalid & s_axi_bready;
    assign ar_fire   = s_axi_arvalid & s_axi_arready;
    assign r_fire    = s_axi_rvalid & s_axi_rready;
    assign wr_commit = aw_hold & w_hold;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], wdata_q, wstrb_q};

    // Write decode and byte-strobe merge
    logic             wr_ok, wr_cfg, wr_out;
    logic [BTN_N-1:0] wr_cnt_clr;
    logic [2:0]       cfg_next;
    logic [OUT_W-1:0] out_next;

    always_comb begin
        wr_ok      = 1'b0;
        wr_cfg     = 1'b0;
        wr_out     = 1'b0;
        wr_cnt_clr = '0;
        if (aw_idx_q == IDX_W'(0)) begin
            wr_ok  = 1'b1;
            wr_cfg = 1'b1;
        end
        if (aw_idx_q == IDX_W'(1)) begin
            wr_ok  = 1'b1;
            wr_out = 1'b1;
        end
        for (int k = 0; k < BTN_N; k++) begin
            if (aw_idx_q == IDX_W'(4 + k)) begin
                wr_ok         = 1'b1;
                wr_cnt_clr[k] = 1'b1;
            end
        end
        cfg_next = wstrb_q[0] ? wdata_q[2:0] : cfg;
        for (int i = 0; i < OUT_W; i++) begin
            out_next[i] = wstrb_q[i/8] ? wdata_q[i] : out_q[i];
        end
    end

    // Read decode straight from the address bus; only sampled on AR accept
    logic [IDX_W-1:0] rd_idx;
    logic             rd_ok;
    logic [31:0]      rd_val;
    logic [BTN_N-1:0] rd_cnt_sel;

    assign rd_idx = s_axi_araddr[ADDR_W-1:2];

    always_comb begin
        rd_ok      = 1'b1;
        rd_val     = '0;
        rd_cnt_sel = '0;
        if (rd_idx == IDX_W'(0))      rd_val = {29'd0, cfg};
        else if (rd_idx == IDX_W'(1)) rd_val = 32'(out_q);
        else if (rd_idx == IDX_W'(2)) rd_val = 32'(in_sync[SYNC_STAGES-1]);
        else if (rd_idx == IDX_W'(3)) rd_val = 32'(btn_sync[SYNC_STAGES-1]);
        else rd_ok = 1'b0;
        for (int k = 0; k < BTN_N; k++) begin
            if (rd_idx == IDX_W'(4 + k)) begin
                rd_ok         = 1'b1;
                rd_val        = 32'(cnt[k]);
                rd_cnt_sel[k] = 1'b1;
            end
        end
    end

    // Counter clear sources and press detection
    logic [BTN_N-1:0] cnt_clr, press;
    logic             any_cnt;

    always_comb begin
        cnt_clr = (wr_commit ? wr_cnt_clr : '0)
                | ((ar_fire & cfg[1]) ? rd_cnt_sel : '0);
        press   = btn_sync[SYNC_STAGES-1] & ~btn_prev & {BTN_N{cfg[0]}};
        any_cnt = 1'b0;
        for (int k = 0; k < BTN_N; k++) begin
            any_cnt = any_cnt | (|cnt[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            aw_hold       <= 1'b0;
            w_hold        <= 1'b0;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            if (aw_fire) begin
                aw_hold       <= 1'b1;
                aw_idx_q      <= s_axi_awaddr[ADDR_W-1:2];
                s_axi_awready <= 1'b0;
            end else if (b_fire || (!aw_hold && !s_axi_bvalid)) begin
                s_axi_awready <= 1'b1;
            end
            if (w_fire) begin
                w_hold       <= 1'b1;
                wdata_q      <= s_axi_wdata;
                wstrb_q      <= s_axi_wstrb;
                s_axi_wready <= 1'b0;
            end else if (b_fire || (!w_hold && !s_axi_bvalid)) begin
                s_axi_wready <= 1'b1;
            end
            if (wr_commit) begin
                aw_hold      <= 1'b0;
                w_hold       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (b_fire) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else if (ar_fire) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= rd_ok ? rd_val : 32'd0;
            s_axi_rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_fire) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
        end else if (!s_axi_rvalid) begin
            s_axi_arready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg      <= 3'b001;
            out_q    <= '0;
            btn_prev <= '0;
            irq      <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                in_sync[s]  <= '0;
                btn_sync[s] <= '0;
            end
            for (int k = 0; k < BTN_N; k++) cnt[k] <= '0;
        end else begin
            if (wr_commit && wr_cfg) cfg   <= cfg_next;
            if (wr_commit && wr_out) out_q <= out_next;
            in_sync[0]  <= gpio_in;
            btn_sync[0] <= btn;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                in_sync[s]  <= in_sync[s-1];
                btn_sync[s] <= btn_sync[s-1];
            end
            btn_prev <= btn_sync[SYNC_STAGES-1];
            // A clear coinciding with a press leaves exactly one count
            for (int k = 0; k < BTN_N; k++) begin
                if (cnt_clr[k])
                    cnt[k] <= press[k] ? CNT_W'(1) : '0;
                else if (press[k] && cnt[k] != CNT_MAX)
                    cnt[k] <= cnt[k] + 1'b1;
            end
            irq <= cfg[2] & any_cnt;
        end
    end

    assign gpio_out = out_q;

endmodule

// File: tb/tb_axi_lite_gpio_param.sv
// Directed bench for axi_lite_gpio_param: register map, strobes, counters,
// clear-on-read, saturation, interrupt, error responses and mid-write reset.
module tb_axi_lite_gpio_param;

    localparam int LIMIT = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [15:0] gpio_in;
    logic [3:0]  btn;
    logic [15:0] gpio_out;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int bcount = 0;

    always #5 clk = ~clk;

    axi_lite_gpio_param #(
        .ADDR_W(6), .OUT_W(16), .IN_W(16), .BTN_N(4), .CNT_W(3), .SYNC_STAGES(2)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .gpio_in(gpio_in), .btn(btn), .gpio_out(gpio_out), .irq(irq)
    );

    always @(posedge clk) begin
        if (rst_n && bvalid && bready) bcount <= bcount + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lag, output logic [1:0] resp);
        int t;
        bit aw_done, w_done;
        aw_done = 0;
        w_done  = 0;
        t       = 0;
        while (!(aw_done && w_done) && t < LIMIT) begin
            @(negedge clk);
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done;
            wvalid  = !w_done && (t >= w_lag);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(posedge clk);
            t++;
        end
        if (t >= LIMIT) check("aw_w_timeout", 32'(t), 32'(LIMIT - 1));
        @(negedge clk);
        awvalid = 0;
        wvalid  = 0;
        bready  = 1;
        t = 0;
        while (!bvalid && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) check("b_timeout", 32'(t), 32'(LIMIT - 1));
        resp = bresp;
        @(posedge clk);
        @(negedge clk);
        bready = 0;
    endtask

    task automatic axi_read(input logic [5:0] addr, input int hold, output logic [31:0] data,
                            output logic [1:0] resp, output int lat, output bit stable);
        int n;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1;
        rready  = 0;
        n = 0;
        while (!arready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("ar_timeout", 32'(n), 32'(LIMIT - 1));
        @(posedge clk);
        @(negedge clk);
        arvalid = 0;
        lat = 1;
        n   = 0;
        while (!rvalid && n < LIMIT) begin
            @(negedge clk);
            lat++;
            n++;
        end
        if (n >= LIMIT) check("r_timeout", 32'(n), 32'(LIMIT - 1));
        data   = rdata;
        resp   = rresp;
        stable = 1;
        repeat (hold) begin
            @(negedge clk);
            if (rdata !== data || rvalid !== 1'b1) stable = 0;
        end
        rready = 1;
        @(posedge clk);
        @(negedge clk);
        rready = 0;
    endtask

    task automatic pulse_btn(input int ch, input int count);
        repeat (count) begin
            @(negedge clk);
            btn[ch] = 1'b1;
            repeat (4) @(negedge clk);
            btn[ch] = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat, b0, n_bv;
        bit          st;

        rst_n = 0; awaddr = 0; araddr = 0; awvalid = 0; wvalid = 0; bready = 0;
        arvalid = 0; rready = 0; wdata = 0; wstrb = 0; gpio_in = 0; btn = 0;
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(awready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_gpio_out", 32'(gpio_out), 0);
        check("rst_irq", 32'(irq), 0);
        rst_n = 1;
        axi_read(6'h00, 0, d, r, lat, st);
        check("rst_config", d, 32'h1);

        // Input port through the synchroniser
        gpio_in = 16'hBABA;
        repeat (4) @(negedge clk);
        axi_read(6'h08, 0, d, r, lat, st);
        check("in_data", d, 32'h0000BABA);
        check("in_resp", 32'(r), 0);
        check("in_latency", 32'(lat), 1);
        axi_read(6'h0C, 0, d, r, lat, st);
        check("btn_all_idle", d, 0);

        // Output register with strobes and staggered W
        b0 = bcount;
        axi_write(6'h04, 32'h0000CECE, 4'hF, 0, r);
        check("out_w1_resp", 32'(r), 0);
        check("out_w1_gpio", 32'(gpio_out), 32'hCECE);
        axi_write(6'h04, 32'h000012AA, 4'b0001, 2, r);
        check("out_w2_gpio", 32'(gpio_out), 32'hCEAA);
        check("out_bcount", 32'(bcount - b0), 2);
        axi_read(6'h04, 0, d, r, lat, st);
        check("out_readback", d, 32'h0000CEAA);
        axi_write(6'h04, 32'h0000FFFF, 4'b0000, 0, r);
        check("out_nostrb_resp", 32'(r), 0);
        check("out_nostrb_gpio", 32'(gpio_out), 32'hCEAA);

        // Press counting and clear-on-read
        pulse_btn(0, 7);
        axi_read(6'h10, 0, d, r, lat, st);
        check("cnt0_first", d, 7);
        axi_read(6'h10, 0, d, r, lat, st);
        check("cnt0_noclr", d, 7);
        axi_write(6'h00, 32'h3, 4'hF, 0, r);
        axi_read(6'h10, 0, d, r, lat, st);
        check("cnt0_cor_old", d, 7);
        axi_read(6'h10, 0, d, r, lat, st);
        check("cnt0_cor_clr", d, 0);
        check("cnt0_irq", 32'(irq), 0);

        // Saturation, interrupt, clear by write
        axi_write(6'h00, 32'h1, 4'hF, 0, r);
        pulse_btn(1, 9);
        axi_read(6'h14, 0, d, r, lat, st);
        check("cnt1_sat", d, 7);
        check("irq_disabled", 32'(irq), 0);
        axi_write(6'h00, 32'h5, 4'hF, 0, r);
        repeat (2) @(negedge clk);
        check("irq_set", 32'(irq), 1);
        axi_write(6'h14, 32'h0, 4'h0, 0, r);
        check("cnt1_clr_resp", 32'(r), 0);
        repeat (2) @(negedge clk);
        check("irq_clr", 32'(irq), 0);
        axi_read(6'h14, 0, d, r, lat, st);
        check("cnt1_cleared", d, 0);

        // Counting disabled, BTN_ALL levels
        axi_write(6'h00, 32'h4, 4'hF, 0, r);
        @(negedge clk);
        btn = 4'b1000;
        repeat (5) @(negedge clk);
        axi_read(6'h0C, 0, d, r, lat, st);
        check("btn_all_level", d, 32'h8);
        axi_read(6'h1C, 0, d, r, lat, st);
        check("cnt3_disabled", d, 0);
        btn = 4'b0000;

        // Error responses and held read data
        axi_read(6'h3C, 0, d, r, lat, st);
        check("unmap_rresp", 32'(r), 32'h2);
        check("unmap_rdata", d, 0);
        axi_read(6'h20, 0, d, r, lat, st);
        check("cnt_oob_rresp", 32'(r), 32'h2);
        axi_write(6'h08, 32'h1234, 4'hF, 0, r);
        check("ro_bresp", 32'(r), 32'h2);
        axi_write(6'h3C, 32'h1234, 4'hF, 1, r);
        check("unmap_bresp", 32'(r), 32'h2);
        axi_read(6'h08, 5, d, r, lat, st);
        check("in_after_ro_write", d, 32'h0000BABA);
        check("rdata_stable", 32'(st), 1);

        // Reset between AW accept and W
        @(negedge clk);
        awaddr  = 6'h04;
        awvalid = 1;
        n_bv    = 0;
        while (!awready && n_bv < LIMIT) begin
            @(negedge clk);
            n_bv++;
        end
        if (n_bv >= LIMIT) check("rst_aw_timeout", 32'(n_bv), 32'(LIMIT - 1));
        @(posedge clk);
        @(negedge clk);
        awvalid = 0;
        rst_n   = 0;
        bready  = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
        n_bv  = 0;
        repeat (6) begin
            @(negedge clk);
            if (bvalid) n_bv++;
        end
        bready = 0;
        check("midrst_no_bvalid", 32'(n_bv), 0);
        check("midrst_gpio_out", 32'(gpio_out), 0);
        axi_read(6'h00, 0, d, r, lat, st);
        check("midrst_config", d, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
